// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request, IF/ID pipeline register.
// A skid buffer holds a word returned under stall; DRAIN swallows a wrong-path in-flight request.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        flushD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    input  logic [31:0] pcjumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic [5:0]  opD
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign redirect = jumpD | pcsrcD;
    assign target   = {(jumpD ? pcjumpD[31:2] : pcbranchD[31:2]), 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        redir_d   = redir_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;

        unique case (state_q)
            StFetch: begin
                if (redirect) begin
                    instr_d = 32'h0; pcplus4_d = 32'h0; valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = target;
                    end else begin
                        redir_d = target;
                        state_d = StDrain;
                    end
                end else if (stallF) begin
                    if (imem_ready) begin
                        buf_d   = imem_rdata;
                        state_d = StHold;
                    end
                end else if (imem_ready) begin
                    instr_d   = imem_rdata;
                    pcplus4_d = pc_plus4;
                    valid_d   = 1'b1;
                    pc_d      = pc_plus4;
                end else begin
                    instr_d = 32'h0; pcplus4_d = 32'h0; valid_d = 1'b0;
                end
            end
            StHold: begin
                if (redirect) begin
                    instr_d = 32'h0; pcplus4_d = 32'h0; valid_d = 1'b0;
                    pc_d    = target;
                    state_d = StFetch;
                end else if (!stallF) begin
                    instr_d   = buf_q;
                    pcplus4_d = pc_plus4;
                    valid_d   = 1'b1;
                    pc_d      = pc_plus4;
                    state_d   = StFetch;
                end
            end
            StDrain: begin
                // The in-flight word is wrong-path; IF/ID only ever sees bubbles here.
                if (redirect || !stallF) begin
                    instr_d = 32'h0; pcplus4_d = 32'h0; valid_d = 1'b0;
                end
                if (imem_ready) begin
                    pc_d    = redirect ? target : redir_q;
                    state_d = StFetch;
                end else if (redirect) begin
                    redir_d = target;
                end
            end
            default: state_d = StFetch;
        endcase

        if (flushD) begin
            instr_d = 32'h0; pcplus4_d = 32'h0; valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            buf_q     <= 32'h0;
            redir_q   <= 32'h0;
            instr_q   <= 32'h0;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            redir_q   <= redir_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_req  = (state_q != StHold) && !reset;
    assign imem_addr = pc_q;
    assign instrD    = instr_q;
    assign pcplus4D  = pcplus4_q;
    assign validD    = valid_q;
    assign opD       = instr_q[31:26];

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stallF  input  1  from hazard unit; hold PC and IF/ID register.
REQ-005 flushD  input  1  from hazard unit; load bubble into IF/ID.
REQ-006 pcsrcD  input  1  branch taken in decode.
REQ-007 pcbranchD  input  32  branch target.
REQ-008 jumpD  input  1  jump in decode.
REQ-009 pcjumpD  input  32  jump target.
REQ-010 imem_req  output  1  instruction memory request valid.
REQ-011 imem_addr  output  32  instruction fetch address.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-013 imem_ready  input  1  request complete; at most one request outstanding.
REQ-014 instrD  output  32  IF/ID instruction; 32'h0000_0000 (nop) when bubble.
REQ-015 pcplus4D  output  32  IF/ID PC+4 of instrD.
REQ-016 validD  output  1  instrD is a real instruction.
REQ-017 opD  output  6  instrD[31:26], op field for the main decoder.

Function
REQ-018 States: FETCH (request in flight), HOLD (word buffered under stall), DRAIN (discarding wrong-path request).
REQ-019 imem_addr SHALL equal pcF; imem_req=1 in FETCH and DRAIN, 0 in HOLD and while reset=1.
REQ-020 Redirect = jumpD|pcsrcD; target = pcjumpD if jumpD else pcbranchD; target[1:0] forced to 2'b00.
REQ-021 Priority per cycle: reset > redirect > stallF > normal.
REQ-022 FETCH, imem_ready=1, no redirect, stallF=0: IF/ID <= {imem_rdata, pcF+4, valid=1}; pcF <= pcF+4; stay FETCH (zero-wait back-to-back fetch, one instruction per cycle).
REQ-023 FETCH, imem_ready=0, no redirect, stallF=0: IF/ID <= bubble; pcF held.
REQ-024 FETCH, imem_ready=1, stallF=1, no redirect: imem_rdata into skid buffer; IF/ID and pcF held; -> HOLD.
REQ-025 FETCH, imem_ready=0, stallF=1: IF/ID and pcF held; stay FETCH.
REQ-026 HOLD, stallF=0, no redirect: IF/ID <= {buffer, pcF+4, valid=1}; pcF <= pcF+4; -> FETCH.
REQ-027 HOLD, stallF=1: no change.
REQ-028 Redirect with imem_ready=1 (FETCH) or in HOLD: returned/buffered word discarded; pcF <= target; -> FETCH.
REQ-029 Redirect in FETCH with imem_ready=0: target saved in redirect register; -> DRAIN; pcF unchanged until drain ends.
REQ-030 DRAIN: imem_addr held at in-flight pcF; on imem_ready=1 word discarded, pcF <= saved target, -> FETCH; a new redirect in DRAIN overwrites saved target.
REQ-031 IF/ID never loads a wrong-path or DRAIN word; validD=0 whenever bubble inserted.
REQ-032 flushD=1: IF/ID <= bubble regardless of stallF; PC-side behaviour per REQ-021..030 unaffected.
REQ-033 pcF+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-034 opD SHALL be combinational from instrD[31:26].

Reset
REQ-035 reset=1 at an edge: pcF <= RESET_PC, state <= FETCH, instrD <= 0, pcplus4D <= 0, validD <= 0, buffer and redirect register cleared.
REQ-036 Reset mid-request or mid-DRAIN: in-flight word discarded; first post-reset request is to RESET_PC with imem_req=1 the cycle after reset deasserts.

Verification
REQ-037 Reset, imem_ready=1 always -> addr 0,4,8 on consecutive cycles; instrD follows one cycle later with pcplus4D 4,8,12, validD=1.
REQ-038 imem_ready low 2 cycles at pc 8 -> two bubbles (validD=0, instrD=0), pc held at 8, then word at 8 delivered with pcplus4D=12.
REQ-039 stallF=1 for 3 cycles as word at 16 returns -> HOLD, imem_req=0, instrD unchanged; stallF drop -> instrD=word16, pcplus4D=20, next addr 20.
REQ-040 pcsrcD=1, pcbranchD=32'h40 while request to 24 pending (ready=0) -> DRAIN; on ready word discarded; next addr 32'h40; no word from 24 reaches instrD.
REQ-041 jumpD=1 and pcsrcD=1 same cycle, pcjumpD=32'h103, pcbranchD=32'h80 -> next addr 32'h100.
REQ-042 flushD=1 with stallF=1 -> instrD=0, validD=0 next cycle; pcF held.
